// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: one decoded write port, two
// combinational read ports (rs, rt), register $0 hardwired to zero.
//
// Ports:
//   clk        - rising-edge clock for all state updates
//   reset      - asynchronous active-high clear of every register
//   write_en   - write strobe, sampled at rising clk
//   write_addr - destination register index
//   write_data - value to store
//   read_addr1 - rs index      read_data1 - contents of rs
//   read_addr2 - rt index      read_data2 - contents of rt
//
// Configuration macro: REGFILE_WRITE_FORWARD_EN
//   When defined, a same-cycle write to the register being read is
//   bypassed straight to the read port. Undefined: reads show stored
//   contents only, so a same-cycle read sees the pre-write value.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  // Row 0 has no storage at all; it is the constant zero.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   row_en;
  logic [DATA_WIDTH-1:0] stored1;
  logic [DATA_WIDTH-1:0] stored2;

  // One-hot write decode; bit 0 is forced low so $0 never loads.
  always_comb begin
    row_en = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      row_en[k] = write_en && (write_addr == ADDR_WIDTH'(k));
    end
  end

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_row
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs[k] <= '0;
      end else if (row_en[k]) begin
        regs[k] <= write_data;
      end
    end
  end

  // Read select muxes; address 0 falls through to the zero default.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (read_addr1 == ADDR_WIDTH'(k)) stored1 = regs[k];
      if (read_addr2 == ADDR_WIDTH'(k)) stored2 = regs[k];
    end
  end

`ifdef REGFILE_WRITE_FORWARD_EN
  logic fwd1;
  logic fwd2;

  assign fwd1 = write_en && (write_addr != '0)
             && (read_addr1 == write_addr);
  assign fwd2 = write_en && (write_addr != '0)
             && (read_addr2 == write_addr);

  // Bypass is masked during reset so outputs stay zero.
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
    if (reset) begin
      read_data1 = '0;
      read_data2 = '0;
    end else begin
      if (fwd1) read_data1 = write_data;
      if (fwd2) read_data2 = write_data;
    end
  end
`else
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
    if (reset) begin
      read_data1 = '0;
      read_data2 = '0;
    end
  end
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file.
// Expected values are hand-computed or held in a small shadow array.
module tb_mips_register_file;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int tests;
  int fails;
  logic [31:0] shadow [32];

  mips_register_file dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the following negedge.
  task automatic do_write(input logic [4:0] a,
                          input logic [31:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    @(posedge clk);
    @(negedge clk);
    write_en   = 1'b0;
    if (a != 5'd0) shadow[a] = d;
  endtask

  task automatic clear_shadow;
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
  endtask

  task automatic test_reset;
    do_write(5'd5, 32'hDEADBEEF);
    read_addr1 = 5'd5;
    #1;
    tests++;
    if (read_data1 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL preload_r5 got %h want %h",
               read_data1, 32'hDEADBEEF);
    end
    // Assert reset between edges: must clear at once.
    reset = 1'b1;
    #1;
    tests++;
    if (read_data1 !== 32'h0) begin
      fails++;
      $display("FAIL async_reset got %h want 0", read_data1);
    end
    // A write across an edge during reset is discarded,
    // and no forwarding shows on the read port.
    write_en   = 1'b1;
    write_addr = 5'd5;
    write_data = 32'h0BAD0BAD;
    #1;
    tests++;
    if (read_data1 !== 32'h0) begin
      fails++;
      $display("FAIL reset_no_fwd got %h want 0", read_data1);
    end
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    reset    = 1'b0;
    clear_shadow();
    #1;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      #1;
      tests++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
        fails++;
        $display("FAIL reset_row%0d got %h/%h want 0/0",
                 i, read_data1, read_data2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_read;
    do_write(5'd7, 32'h12345678);
    read_addr1 = 5'd7;
    read_addr2 = 5'd7;
    #1;
    tests++;
    if (read_data1 !== 32'h12345678 ||
        read_data2 !== 32'h12345678) begin
      fails++;
      $display("FAIL wr_r7 got %h/%h want %h",
               read_data1, read_data2, 32'h12345678);
    end
    read_addr1 = 5'd6;
    read_addr2 = 5'd8;
    #1;
    tests++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      fails++;
      $display("FAIL r6_r8 got %h/%h want 0/0",
               read_data1, read_data2);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_reg;
    do_write(5'd0, 32'hFFFFFFFF);
    read_addr1 = 5'd0;
    read_addr2 = 5'd0;
    #1;
    tests++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      fails++;
      $display("FAIL r0_read got %h/%h want 0/0",
               read_data1, read_data2);
    end
    for (int i = 1; i < 32; i++) begin
      read_addr1 = 5'(i);
      #1;
      tests++;
      if (read_data1 !== shadow[i]) begin
        fails++;
        $display("FAIL r0_side_r%0d got %h want %h",
                 i, read_data1, shadow[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_disable;
    do_write(5'd3, 32'h00000011);
    write_en   = 1'b0;
    write_addr = 5'd3;
    write_data = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    read_addr1 = 5'd3;
    #1;
    tests++;
    if (read_data1 !== 32'h00000011) begin
      fails++;
      $display("FAIL we0_r3 got %h want %h",
               read_data1, 32'h00000011);
    end
    @(negedge clk);
  endtask

  task automatic test_hazard;
    logic [31:0] want;
`ifdef REGFILE_WRITE_FORWARD_EN
    want = 32'h2;
`else
    want = 32'h1;
`endif
    do_write(5'd9, 32'h1);
    write_en   = 1'b1;
    write_addr = 5'd9;
    write_data = 32'h2;
    read_addr1 = 5'd9;
    #1;
    tests++;
    if (read_data1 !== want) begin
      fails++;
      $display("FAIL hazard_same got %h want %h",
               read_data1, want);
    end
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    shadow[9] = 32'h2;
    #1;
    tests++;
    if (read_data1 !== 32'h2) begin
      fails++;
      $display("FAIL hazard_next got %h want 2", read_data1);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    logic [31:0] w1;
    logic [31:0] w2;
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      w1 = 32'(i) * 32'h01010101;
      w2 = 32'(31 - i) * 32'h01010101;
      #1;
      tests++;
      if (read_data1 !== w1 || read_data2 !== w2) begin
        fails++;
        $display("FAIL sweep_%0d got %h/%h want %h/%h",
                 i, read_data1, read_data2, w1, w2);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    write_en   = 1'b0;
    write_addr = 5'd0;
    write_data = 32'h0;
    read_addr1 = 5'd0;
    read_addr2 = 5'd0;
    clear_shadow();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_write_disable();
    test_hazard();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
